poly_datapath: RTL and testbench
================================

// Module: poly_datapath
// PURPOSE
//   Operative block (datapath) driven by the polynomial control block: receives its control word
//   (lx, lh, ls, h, m0, m1, m2, ready, done), holds working registers X/H/S, runs one ALU op per
//   cycle and captures the final S as the result when done is asserted.
//   Computes y = a*x^2 + b*x + c under a 6-step control sequence.
// PARAMETERS
//   W   8   data width of x_in, coefficients, X/H/S and result (unsigned)
// PORTS
//   clk           in   1  clock, rising edge
//   rst           in   1  reset, synchronous, active-high
//   x_in          in   W  operand x, loaded into X on lx
//   coef_a/b/c    in   W  polynomial coefficients, sampled combinationally each cycle
//   lx, lh, ls    in   1  load enables for X, H, S
//   h             in   1  ALU op: 1 = multiply, 0 = add
//   m0            in   2  operand P select: 0 X, 1 H, 2 S, 3 coef_c
//   m1            in   2  operand Q select: 0 X, 1 coef_a, 2 coef_b, 3 H
//   m2            in   2  writeback select: 0 ALU, 1 P, 2 Q, 3 zero
//   ready         in   1  controller idle (state 0)
//   done          in   1  controller final step
//   result        out  W  captured S
//   result_valid  out  1  one-cycle pulse, result updated
//   ovf           out  1  sticky arithmetic overflow for current computation
//   proto_err     out  1  sticky: lh/ls/lx asserted while ready=1
// BEHAVIOUR
//   - Reset: X=H=S=0, result=0, result_valid=0, ovf=0, proto_err=0. Reset wins over all loads.
//   - Writeback bus WB = mux(m2) of {ALU(P,Q), P, Q, 0}. On a rising edge: lx -> X<=x_in;
//     lh -> H<=WB; ls -> S<=WB. lh&ls same cycle: both load the same WB. lx is independent
//     (X loads x_in, never WB); a same-cycle read of X in P/Q sees the old X.
//   - ALU: add or multiply, full-precision internally (2W bits for mul, W+1 for add), then
//     truncated to W bits (wrap-around, mod 2^W).
//   - ovf: set on any edge where (lh|ls) & m2==0 and the full result exceeds 2^W-1.
//     Cleared on lx (new computation start); rst clears. Set and clear in same cycle: set wins.
//   - Result: edge with done=1 -> result<=S (pre-edge S), result_valid<=1 next cycle only.
//     done held 2+ cycles -> recapture and pulse each cycle. result holds until next done.
//   - proto_err: set when ready=1 and any of lx/lh/ls=1; loads still performed; cleared by rst only.
//   - Latency: every register op is 1 cycle; result visible 1 cycle after done cycle.
//   - Reset mid-sequence: all state cleared same edge, no result_valid pulse, ovf cleared.
// CONFIGURATION
//   SATURATE_EN defined: ALU result exceeding 2^W-1 is clamped to 2^W-1 instead of wrapped;
//   ovf still set identically. Undefined: wrap-around (mod 2^W) as above.
// STRUCTURE
//   Package poly_pkg: mux encodings (P_X, P_H, P_S, P_C; Q_X, Q_A, Q_B, Q_H; WB_ALU, WB_P,
//   WB_Q, WB_ZERO) and op codes (OP_ADD=0, OP_MUL=1), shared with the control block.
//   Sub-module poly_alu: combinational add/mul, overflow detect, optional saturation.
//   Registers, muxes, result capture and flags in poly_datapath.
// TESTING
//   1 Reset: rst=1 for 2 cycles -> X=H=S=0, result=0, result_valid=0, ovf=0, proto_err=0.
//   2 Full sequence a=2,b=3,c=4,x_in=3 (lx; H=X*X m0=0 m1=0 h=1; H=H*a m0=1 m1=1; S=X*b m0=0
//     m1=2 ls; H=c+H m0=3 m1=3 h=0; S=S+H m0=2 m1=3 ls; done) -> result=31, result_valid
//     one cycle, ovf=0.
//   3 Overflow W=8, x_in=20, H=X*X -> H=144, ovf=1; with SATURATE_EN H=255, ovf=1;
//     next lx -> ovf=0.
//   4 lh&ls together, m2=2 (Q), m1=1, coef_a=7 -> H=S=7 next cycle.
//   5 rst asserted during step 4 of the sequence of test 2, done 2 cycles later
//     -> X=H=S=0 after reset, result=0 until done, no pulse during reset.
//   6 ready=1 with ls=1 -> proto_err=1 and stays 1 until rst; S still loads WB.

Source files
------------

// File: rtl/poly_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_pkg
//  Description : Shared encodings for the polynomial datapath and its control
//                block: operand-P select, operand-Q select, writeback select
//                and ALU op codes.
//  Revision    : 1.0  initial release
// ============================================================================
package poly_pkg;

    // Operand P select (m0)
    typedef enum logic [1:0] {
        P_X = 2'd0,
        P_H = 2'd1,
        P_S = 2'd2,
        P_C = 2'd3
    } p_sel_e;

    // Operand Q select (m1)
    typedef enum logic [1:0] {
        Q_X = 2'd0,
        Q_A = 2'd1,
        Q_B = 2'd2,
        Q_H = 2'd3
    } q_sel_e;

    // Writeback bus select (m2)
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_P    = 2'd1,
        WB_Q    = 2'd2,
        WB_ZERO = 2'd3
    } wb_sel_e;

    // ALU op (h)
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } alu_op_e;

endpackage : poly_pkg
`default_nettype wire

// File: rtl/poly_alu.sv
`default_nettype none
// ============================================================================
//  Module      : poly_alu
//  Description : Combinational add / multiply for the polynomial datapath.
//                The operation is carried out at full precision (2W bits),
//                overflow is flagged when the full result exceeds 2^W-1 and
//                the W-bit output is either wrapped (mod 2^W) or clamped.
//  Config      : SATURATE_EN - defined: clamp to 2^W-1 on overflow;
//                              undefined: wrap-around.
//  Ports       : i_p, i_q  W-bit unsigned operands
//                i_op      OP_ADD / OP_MUL
//                o_y       W-bit result
//                o_ovf     full-precision result exceeds 2^W-1
//  Revision    : 1.0  initial release
// ============================================================================
module poly_alu
    import poly_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_p,
    input  logic [W-1:0] i_q,
    input  alu_op_e      i_op,
    output logic [W-1:0] o_y,
    output logic         o_ovf
);

    logic [2*W-1:0] w_full;

    // Both ops are widened to 2W so a single upper-half test covers overflow.
    always_comb begin
        w_full = '0;
        if (i_op == OP_MUL) begin
            w_full = {{W{1'b0}}, i_p} * {{W{1'b0}}, i_q};
        end else begin
            w_full = {{(W-1){1'b0}}, ({1'b0, i_p} + {1'b0, i_q})};
        end
    end

    assign o_ovf = |w_full[2*W-1:W];

`ifdef SATURATE_EN
    assign o_y = o_ovf ? {W{1'b1}} : w_full[W-1:0];
`else
    assign o_y = w_full[W-1:0];
`endif

endmodule : poly_alu
`default_nettype wire

// File: rtl/poly_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : poly_datapath
//  Description : Operative block for y = a*x^2 + b*x + c. Holds working
//                registers X/H/S, executes one ALU op per cycle under the
//                control word from the polynomial controller and captures S
//                as the result on done.
//  Config      : SATURATE_EN - ALU clamps instead of wrapping (see poly_alu).
//  Ports       : clk, rst            clock / sync active-high reset
//                x_in                operand x (loaded into X on lx)
//                coef_a/b/c          coefficients, used combinationally
//                lx, lh, ls          load enables for X, H, S
//                h                   ALU op (1 mul, 0 add)
//                m0, m1, m2          P select, Q select, writeback select
//                ready, done         controller idle / final step
//                result              captured S
//                result_valid        one-cycle pulse after each capture
//                ovf                 sticky overflow for current computation
//                proto_err           sticky load-while-idle indication
//  Revision    : 1.0  initial release
// ============================================================================
module poly_datapath
    import poly_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] coef_a,
    input  logic [W-1:0] coef_b,
    input  logic [W-1:0] coef_c,
    input  logic         lx,
    input  logic         lh,
    input  logic         ls,
    input  logic         h,
    input  logic [1:0]   m0,
    input  logic [1:0]   m1,
    input  logic [1:0]   m2,
    input  logic         ready,
    input  logic         done,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         ovf,
    output logic         proto_err
);

    logic [W-1:0] r_x;
    logic [W-1:0] r_h;
    logic [W-1:0] r_s;
    logic [W-1:0] r_result;
    logic         r_result_valid;
    logic         r_ovf;
    logic         r_proto_err;

    logic [W-1:0] w_p;
    logic [W-1:0] w_q;
    logic [W-1:0] w_wb;
    logic [W-1:0] w_alu_y;
    logic         w_alu_ovf;
    logic         w_ovf_set;

    // ------------------------------------------------------------------
    // Operand and writeback muxes
    // ------------------------------------------------------------------
    always_comb begin
        w_p = '0;
        case (p_sel_e'(m0))
            P_X:     w_p = r_x;
            P_H:     w_p = r_h;
            P_S:     w_p = r_s;
            P_C:     w_p = coef_c;
            default: w_p = '0;
        endcase
    end

    always_comb begin
        w_q = '0;
        case (q_sel_e'(m1))
            Q_X:     w_q = r_x;
            Q_A:     w_q = coef_a;
            Q_B:     w_q = coef_b;
            Q_H:     w_q = r_h;
            default: w_q = '0;
        endcase
    end

    poly_alu #(
        .W (W)
    ) u_alu (
        .i_p   (w_p),
        .i_q   (w_q),
        .i_op  (alu_op_e'(h)),
        .o_y   (w_alu_y),
        .o_ovf (w_alu_ovf)
    );

    always_comb begin
        w_wb = '0;
        case (wb_sel_e'(m2))
            WB_ALU:  w_wb = w_alu_y;
            WB_P:    w_wb = w_p;
            WB_Q:    w_wb = w_q;
            WB_ZERO: w_wb = '0;
            default: w_wb = '0;
        endcase
    end

    // Overflow only counts when the ALU result actually lands in a register.
    assign w_ovf_set = (lh | ls) & (wb_sel_e'(m2) == WB_ALU) & w_alu_ovf;

    // ------------------------------------------------------------------
    // Working registers. X always loads x_in, never the writeback bus, so
    // a same-cycle read of X through P/Q sees the pre-edge value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_h <= '0;
            r_s <= '0;
        end else begin
            if (lx) r_x <= x_in;
            if (lh) r_h <= w_wb;
            if (ls) r_s <= w_wb;
        end
    end

    // ------------------------------------------------------------------
    // Result capture: pre-edge S, pulse on the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= done;
            if (done) r_result <= r_s;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags. On ovf, a set in the same cycle as lx wins over the
    // clear so an overflowing first step is not lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf       <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (lx) begin
                r_ovf <= 1'b0;
            end
            if (ready & (lx | lh | ls)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign ovf          = r_ovf;
    assign proto_err    = r_proto_err;

endmodule : poly_datapath
`default_nettype wire

// File: tb/tb_poly_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_datapath
//  Description : Self-checking bench for poly_datapath. A behavioural model
//                tracks X/H/S, result and flags with integer arithmetic;
//                directed sequences are followed by randomized control words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_poly_datapath;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] x_in, coef_a, coef_b, coef_c;
    logic         lx, lh, ls, h;
    logic [1:0]   m0, m1, m2;
    logic         ready, done;
    logic [W-1:0] result;
    logic         result_valid, ovf, proto_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int mx, mh, ms, mres, mrv, movf, mperr;

    always #5 clk = ~clk;

    poly_datapath #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .x_in         (x_in),
        .coef_a       (coef_a),
        .coef_b       (coef_b),
        .coef_c       (coef_c),
        .lx           (lx),
        .lh           (lh),
        .ls           (ls),
        .h            (h),
        .m0           (m0),
        .m1           (m1),
        .m2           (m2),
        .ready        (ready),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .ovf          (ovf),
        .proto_err    (proto_err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ctl(input bit ilx, input bit ilh, input bit ils, input bit ih,
                       input int im0, input int im1, input int im2);
        lx = ilx; lh = ilh; ls = ils; h = ih;
        m0 = 2'(im0); m1 = 2'(im1); m2 = 2'(im2);
    endtask

    task automatic idle();
        ctl(0, 0, 0, 0, 0, 0, 0);
        done = 0; ready = 0; rst = 0;
    endtask

    // One clock: compute the expected next state from the present inputs,
    // take the edge, then compare every observable.
    task automatic cycle(input string tag);
        int p, q, full, alu, wb;
        int nx, nh, ns, nres, nrv, novf, nperr;
        case (int'(m0))
            0: p = mx;
            1: p = mh;
            2: p = ms;
            default: p = int'(coef_c);
        endcase
        case (int'(m1))
            0: q = mx;
            1: q = int'(coef_a);
            2: q = int'(coef_b);
            default: q = mh;
        endcase
        full = h ? p * q : p + q;
`ifdef SATURATE_EN
        alu = (full > MAXV) ? MAXV : full;
`else
        alu = full % (MAXV + 1);
`endif
        case (int'(m2))
            0: wb = alu;
            1: wb = p;
            2: wb = q;
            default: wb = 0;
        endcase
        if (rst) begin
            nx = 0; nh = 0; ns = 0; nres = 0; nrv = 0; novf = 0; nperr = 0;
        end else begin
            nx    = lx ? int'(x_in) : mx;
            nh    = lh ? wb : mh;
            ns    = ls ? wb : ms;
            nres  = done ? ms : mres;
            nrv   = done ? 1 : 0;
            if ((lh || ls) && m2 == 2'd0 && full > MAXV) novf = 1;
            else if (lx)                                 novf = 0;
            else                                         novf = movf;
            nperr = (mperr != 0 || (ready && (lx || lh || ls))) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        mx = nx; mh = nh; ms = ns; mres = nres; mrv = nrv; movf = novf; mperr = nperr;
        chk({tag, ".X"},   int'(dut.r_x),       mx);
        chk({tag, ".H"},   int'(dut.r_h),       mh);
        chk({tag, ".S"},   int'(dut.r_s),       ms);
        chk({tag, ".res"}, int'(result),        mres);
        chk({tag, ".rv"},  int'(result_valid),  mrv);
        chk({tag, ".ovf"}, int'(ovf),           movf);
        chk({tag, ".perr"},int'(proto_err),     mperr);
    endtask

    initial begin
        mx = 0; mh = 0; ms = 0; mres = 0; mrv = 0; movf = 0; mperr = 0;
        idle();
        x_in = '0; coef_a = 8'd2; coef_b = 8'd3; coef_c = 8'd4;

        // 1: reset
        rst = 1;
        cycle("t1_rst0");
        cycle("t1_rst1");
        chk("t1_result", int'(result), 0);
        chk("t1_proto", int'(proto_err), 0);
        rst = 0;

        // 2: full sequence a=2 b=3 c=4 x=3 -> 31
        x_in = 8'd3;
        ctl(1, 0, 0, 0, 0, 0, 0); cycle("t2_lx");
        ctl(0, 1, 0, 1, 0, 0, 0); cycle("t2_xx");
        ctl(0, 1, 0, 1, 1, 1, 0); cycle("t2_ha");
        ctl(0, 0, 1, 1, 0, 2, 0); cycle("t2_xb");
        ctl(0, 1, 0, 0, 3, 3, 0); cycle("t2_ch");
        ctl(0, 0, 1, 0, 2, 3, 0); cycle("t2_sh");
        idle(); done = 1;         cycle("t2_done");
        chk("t2_result", int'(result), 31);
        chk("t2_rv", int'(result_valid), 1);
        chk("t2_ovf", int'(ovf), 0);
        idle();                   cycle("t2_after");
        chk("t2_rv_drop", int'(result_valid), 0);
        chk("t2_hold", int'(result), 31);

        // 3: overflow 20*20
        x_in = 8'd20;
        ctl(1, 0, 0, 0, 0, 0, 0); cycle("t3_lx");
        ctl(0, 1, 0, 1, 0, 0, 0); cycle("t3_mul");
`ifdef SATURATE_EN
        chk("t3_h", int'(dut.r_h), 255);
`else
        chk("t3_h", int'(dut.r_h), 144);
`endif
        chk("t3_ovf", int'(ovf), 1);
        ctl(1, 0, 0, 0, 0, 0, 0); cycle("t3_clr");
        chk("t3_ovf_clr", int'(ovf), 0);

        // 4: lh & ls, WB = Q = coef_a
        coef_a = 8'd7;
        ctl(0, 1, 1, 0, 0, 1, 2); cycle("t4_both");
        chk("t4_h", int'(dut.r_h), 7);
        chk("t4_s", int'(dut.r_s), 7);

        // 5: reset during step 4 of the sequence, done two cycles later
        coef_a = 8'd2; x_in = 8'd3;
        ctl(1, 0, 0, 0, 0, 0, 0); cycle("t5_lx");
        ctl(0, 1, 0, 1, 0, 0, 0); cycle("t5_xx");
        ctl(0, 1, 0, 1, 1, 1, 0); cycle("t5_ha");
        ctl(0, 0, 1, 1, 0, 2, 0); rst = 1; cycle("t5_rst");
        chk("t5_rv_rst", int'(result_valid), 0);
        idle();                   cycle("t5_gap");
        done = 1;                 cycle("t5_done");
        chk("t5_result", int'(result), 0);

        // 6: load while ready
        idle(); x_in = 8'd9;
        ctl(1, 0, 0, 0, 0, 0, 0); cycle("t6_lx");
        ready = 1; ctl(0, 0, 1, 0, 0, 0, 1); cycle("t6_ls");
        chk("t6_perr", int'(proto_err), 1);
        chk("t6_s", int'(dut.r_s), 9);
        idle(); ready = 1;        cycle("t6_hold");
        chk("t6_sticky", int'(proto_err), 1);
        idle(); rst = 1;          cycle("t6_rst");
        rst = 0;

        // randomized control words; done may be held for several cycles
        for (int i = 0; i < 300; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            x_in   = W'($urandom);
            coef_a = W'($urandom);
            coef_b = W'($urandom);
            coef_c = W'($urandom);
            ctl(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
            ready  = ($urandom_range(0, 9) == 0);
            done   = ($urandom_range(0, 4) == 0);
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_poly_datapath
`default_nettype wire
